// File: rtl/mux3_pkg.sv
// Shared constants and word type for the mux3 selector.
package mux3_pkg;

   localparam int MUX3_WIDTH = 16;
   localparam int MUX3_SEL_W = 3;
   localparam int MUX3_N     = 2 ** MUX3_SEL_W;

   typedef logic [MUX3_WIDTH-1:0] mux3_word_t;

endpackage : mux3_pkg

// File: rtl/mux3_dec.sv
// Binary-to-one-hot decoder for the mux3 select input; purely combinational.
import mux3_pkg::*;

module mux3_dec #(
   parameter int SEL_W = MUX3_SEL_W,
   parameter int N     = 2 ** SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = (sel == SEL_W'(i));
      end
   end

endmodule : mux3_dec

// File: rtl/mux3.sv
// N-to-1 word selector built as AND-OR over a one-hot decode of sel.
// Define MUX3_REG_OUT_EN to register out (one-cycle latency, async reset to 0).
import mux3_pkg::*;

module mux3 #(
   parameter int WIDTH = MUX3_WIDTH,
   parameter int SEL_W = MUX3_SEL_W,
   parameter int N     = 2 ** SEL_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N-1:0][WIDTH-1:0]  in,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         out
);

   logic [N-1:0]     onehot;
   logic [WIDTH-1:0] sel_word;

   mux3_dec #(
      .SEL_W (SEL_W),
      .N     (N)
   ) u_dec (
      .sel    (sel),
      .onehot (onehot)
   );

   // Each word is gated by its decode bit; only one bit is ever high.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < N; i++) begin
         sel_word = sel_word | (in[i] & {WIDTH{onehot[i]}});
      end
   end

`ifdef MUX3_REG_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= sel_word;
      end
   end
`else
   // Clock and reset stay on the port list so both builds share one interface.
   logic unused_clk_rst;
   assign unused_clk_rst = clk & rst_n;
   assign out = sel_word;
`endif

endmodule : mux3

// File: tb/tb_mux3.sv
// Directed self-checking bench for mux3; covers the default combinational
// build and, when MUX3_REG_OUT_EN is defined, the registered build.
module tb_mux3;

   localparam int WIDTH = 16;
   localparam int SEL_W = 3;
   localparam int N     = 8;

   logic                    clk;
   logic                    rst_n;
   logic [N-1:0][WIDTH-1:0] din;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out;

   logic [WIDTH-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   mux3 #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (din),
      .sel   (sel),
      .out   (out)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #90000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard: expected values are queued, then compared against out.
   task automatic expect_word(input logic [WIDTH-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag);
      logic [WIDTH-1:0] exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      assert (out === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, out, exp_v);
      end
   endtask

   // Driver tasks
   task automatic load_ramp();
      for (int i = 0; i < N; i++) din[i] = WIDTH'(i);
   endtask

   task automatic drive_sel(input int s);
      sel = SEL_W'(s);
   endtask

   initial begin
      rst_n = 1'b0;
      din   = '0;
      sel   = '0;
      #1;

`ifdef MUX3_REG_OUT_EN
      // Reset forces zero with no clock edge needed.
      expect_word(16'h0000); check("reset_async");
      load_ramp();
      drive_sel(5);
      @(posedge clk); #1;
      expect_word(16'h0000); check("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_word(16'h0000); check("post_release_pre_edge");
      @(posedge clk); #1;
      expect_word(16'h0005); check("first_edge_sel5");

      // One-cycle latency sweep: old value before edge, new value after.
      for (int s = 0; s < N; s++) begin
         logic [WIDTH-1:0] prev;
         prev = out;
         @(negedge clk);
         drive_sel(s);
         #1;
         expect_word(prev); check("sweep_pre_edge");
         @(posedge clk); #1;
         expect_word(WIDTH'(s)); check("sweep_post_edge");
      end

      // Mid-operation reset between edges discards held 0x0007.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expect_word(16'h0000); check("mid_reset_async");
      @(posedge clk); #1;
      expect_word(16'h0000); check("mid_reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
      drive_sel(2);
      #1;
      expect_word(16'h0000); check("mid_release_pre_edge");
      @(posedge clk); #1;
      expect_word(16'h0002); check("mid_release_sel2");

      // Full-width pattern passes unmodified.
      @(negedge clk);
      din[6] = 16'hA5C3;
      drive_sel(6);
      @(posedge clk); #1;
      expect_word(16'hA5C3); check("reg_width_pattern");
`else
      rst_n = 1'b1;
      // Ramp sweep: out tracks sel in the same step.
      load_ramp();
      for (int s = 0; s < N; s++) begin
         drive_sel(s);
         #1;
         expect_word(WIDTH'(s)); check("ramp_sweep");
         #9;
      end

      // Only the top word set.
      din = '0;
      din[7] = 16'hFFFF;
      drive_sel(7);
      #1;
      expect_word(16'hFFFF); check("top_word_sel7");
      drive_sel(6);
      #1;
      expect_word(16'h0000); check("top_word_sel6");

      // Data change on the selected word with sel held.
      din = '0;
      din[3] = 16'h1234;
      drive_sel(3);
      #1;
      expect_word(16'h1234); check("sel3_initial");
      din[3] = 16'hBEEF;
      #0;
      #1;
      expect_word(16'hBEEF); check("sel3_follow");
      din[2] = 16'h5A5A;
      #1;
      expect_word(16'hBEEF); check("sel3_ignore_other");

      // Bit patterns pass unmodified (no sign extension or reordering).
      din[0] = 16'h8001;
      din[5] = 16'h7FFE;
      drive_sel(0);
      #1;
      expect_word(16'h8001); check("pattern_sel0");
      drive_sel(5);
      #1;
      expect_word(16'h7FFE); check("pattern_sel5");

      // Reset and clock have no effect on the combinational output.
      rst_n = 1'b0;
      #1;
      expect_word(16'h7FFE); check("rst_no_effect");
      @(posedge clk); #1;
      expect_word(16'h7FFE); check("clk_no_effect");
      rst_n = 1'b1;
      #1;
      expect_word(16'h7FFE); check("rst_release_no_effect");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux3
